// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer: round-robin sequencer of register-to-register moves over a shared tri-state bus (req/req_src/req_dst in; ack/err, reg_enable/reg_latch, busy/grant_id out)
module bus_transfer_sequencer #(
  parameter int NUM_REGS = 4,
  parameter int NUM_REQ = 2,
  parameter int SETTLE_CYCLES = 1,
  localparam int SRC_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1,
  localparam int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*SRC_W-1:0]  req_src,
  input  logic [NUM_REQ*NUM_REGS-1:0] req_dst,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        err,
  output logic [NUM_REGS-1:0]       reg_enable,
  output logic [NUM_REGS-1:0]       reg_latch,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);
  typedef enum logic [1:0] {IDLE, DRIVE, LATCH, DONE} state_t;
  function automatic logic [NUM_REGS-1:0] onehot(input logic [SRC_W-1:0] s);
    return NUM_REGS'(1) << s;
  endfunction
  state_t state, nxt_state;
  logic [3:0] cnt, nxt_cnt;
  logic [SRC_W-1:0] src_q, nxt_src, w_src;
  logic [NUM_REGS-1:0] dst_q, nxt_dst, w_dst, w_eff, nxt_en, nxt_lat;
  logic [ID_W-1:0] id_q, nxt_id, rr_last, nxt_rr, win;
  logic rej_q, nxt_rej, w_rej, found, act;
  logic [NUM_REQ-1:0] ack_mask, elig, nxt_ack, nxt_err;
  always_comb begin
    elig = req & ~ack_mask;
    win = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++)
      if (!found && elig[ID_W'((int'(rr_last) + k) % NUM_REQ)]) begin
        win = ID_W'((int'(rr_last) + k) % NUM_REQ);
        found = 1'b1;
      end
  end
  assign w_src = req_src[int'(win)*SRC_W +: SRC_W];
  assign w_dst = req_dst[int'(win)*NUM_REGS +: NUM_REGS];
  assign w_eff = w_dst & ~onehot(w_src);
  assign w_rej = int'(w_src) >= NUM_REGS || w_eff == '0;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      src_q <= '0;
      dst_q <= '0;
      id_q <= '0;
      rej_q <= 1'b0;
      rr_last <= ID_W'(NUM_REQ - 1);
      ack_mask <= '0;
      reg_enable <= '0;
      reg_latch <= '0;
      ack <= '0;
      err <= '0;
      busy <= 1'b0;
      grant_id <= '0;
    end else begin
      state <= nxt_state;
      cnt <= nxt_cnt;
      src_q <= nxt_src;
      dst_q <= nxt_dst;
      id_q <= nxt_id;
      rej_q <= nxt_rej;
      rr_last <= nxt_rr;
      ack_mask <= state == DONE ? NUM_REQ'(1) << id_q : '0;
      reg_enable <= nxt_en;
      reg_latch <= nxt_lat;
      ack <= nxt_ack;
      err <= nxt_err;
      busy <= nxt_state != IDLE;
      grant_id <= nxt_state == IDLE ? '0 : nxt_id;
    end
  always_comb begin
    nxt_state = state;
    nxt_cnt = cnt;
    nxt_src = src_q;
    nxt_dst = dst_q;
    nxt_id = id_q;
    nxt_rej = rej_q;
    nxt_rr = rr_last;
    unique case (state)
      IDLE: if (found) begin
        nxt_src = w_src;
        nxt_dst = w_eff;
        nxt_id = win;
        nxt_rej = w_rej;
        nxt_rr = win;
        nxt_cnt = 4'(SETTLE_CYCLES - 1);
        nxt_state = w_rej ? DONE : SETTLE_CYCLES == 0 ? LATCH : DRIVE;
      end
      DRIVE: begin
        nxt_cnt = cnt - 4'd1;
        nxt_state = cnt == '0 ? LATCH : DRIVE;
      end
      LATCH: nxt_state = DONE;
      default: nxt_state = IDLE;
    endcase
  end
  // Outputs are registered copies of what the next state will present.
  always_comb begin
    act = nxt_state == DRIVE || nxt_state == LATCH;
    nxt_en = act ? onehot(nxt_src) : '0;
    nxt_lat = nxt_state == LATCH ? nxt_dst : '0;
    nxt_ack = nxt_state == DONE ? NUM_REQ'(1) << nxt_id : '0;
    nxt_err = nxt_rej ? nxt_ack : '0;
  end
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// tb_bus_transfer_sequencer: directed and randomized checks of bus_transfer_sequencer against a transfer-schedule model
module tb_bus_transfer_sequencer;
  localparam int S = 1;
  localparam int NT = 500;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic [2:0][1:0] req, ack, err;
  logic [2:0][3:0] rsrc, en, lat;
  logic [2:0][7:0] rdst;
  logic [2:0] busy, gid;
  int checks = 0, errors = 0;
  int tg, ts, te, tid, tend, free_at, mask_id, rr, issued, dones, off, w;
  logic trej, e_busy;
  logic [1:0] m, elig, e_ack;
  logic [3:0] e_en, e_lat;
  logic [7:0] ref_r [4], env_r [4];
  logic [7:0] bus;
  int t2_en [12] = '{1, 1, 0, 0, 8, 8, 0, 0, 1, 1, 0, 0};
  int t2_lat [12] = '{0, 2, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0};
  int t2_ack [12] = '{0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 1, 0};
  int t2_busy [12] = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0};
  int t2_gid [12] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
  bus_transfer_sequencer #(.SETTLE_CYCLES(1)) dut (.clk(clk), .reset(reset), .req(req[0]), .req_src(rsrc[0]), .req_dst(rdst[0]),
    .ack(ack[0]), .err(err[0]), .reg_enable(en[0]), .reg_latch(lat[0]), .busy(busy[0]), .grant_id(gid[0]));
  bus_transfer_sequencer #(.SETTLE_CYCLES(0)) dut_s0 (.clk(clk), .reset(reset), .req(req[1]), .req_src(rsrc[1]), .req_dst(rdst[1]),
    .ack(ack[1]), .err(err[1]), .reg_enable(en[1]), .reg_latch(lat[1]), .busy(busy[1]), .grant_id(gid[1]));
  bus_transfer_sequencer #(.SETTLE_CYCLES(3)) dut_s3 (.clk(clk), .reset(reset), .req(req[2]), .req_src(rsrc[2]), .req_dst(rdst[2]),
    .ack(ack[2]), .err(err[2]), .reg_enable(en[2]), .reg_latch(lat[2]), .busy(busy[2]), .grant_id(gid[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask
  task automatic exp_out(input int i, input string tag, input logic [3:0] x_en, input logic [3:0] x_lat,
                         input logic [1:0] x_ack, input logic [1:0] x_err, input logic x_busy);
    chk({tag, ".en"}, en[i], x_en);
    chk({tag, ".lat"}, lat[i], x_lat);
    chk({tag, ".ack"}, ack[i], x_ack);
    chk({tag, ".err"}, err[i], x_err);
    chk({tag, ".busy"}, busy[i], x_busy);
  endtask
  initial begin
    req = '0;
    rsrc = '0;
    rdst = '0;
    reset = 1'b1;
    step();
    step();
    exp_out(0, "rst", 0, 0, 0, 0, 0);
    chk("rst.gid", gid[0], 0);
    reset = 1'b0;
    req[0] = 2'b01; rsrc[0] = 4'b0001; rdst[0] = 8'h04;
    step(); exp_out(0, "t1c1", 4'b0010, 0, 0, 0, 1);
    step(); exp_out(0, "t1c2", 4'b0010, 4'b0100, 0, 0, 1);
    step(); exp_out(0, "t1c3", 0, 0, 2'b01, 0, 1);
    req[0] = 2'b00;
    step(); exp_out(0, "t1c4", 0, 0, 0, 0, 0);
    do_reset();
    req[0] = 2'b11; rsrc[0] = 4'b1100; rdst[0] = 8'h12;
    for (int c = 0; c < 12; c++) begin
      step();
      exp_out(0, $sformatf("t2c%0d", c + 1), 4'(t2_en[c]), 4'(t2_lat[c]), 2'(t2_ack[c]), 2'b00, 1'(t2_busy[c]));
      chk($sformatf("t2c%0d.gid", c + 1), gid[0], t2_gid[c]);
      if (c == 8) req[0] = 2'b00;
    end
    step();
    req[0] = 2'b10; rsrc[0] = 4'b1000; rdst[0] = 8'h40;
    step(); exp_out(0, "t3c1", 0, 0, 2'b10, 2'b10, 1);
    req[0] = 2'b00;
    step(); exp_out(0, "t3c2", 0, 0, 0, 0, 0);
    req[1] = 2'b01; rsrc[1] = 4'b0000; rdst[1] = 8'h0e;
    step(); exp_out(1, "t4c1", 4'b0001, 4'b1110, 0, 0, 1);
    step(); exp_out(1, "t4c2", 0, 0, 2'b01, 0, 1);
    req[1] = 2'b00;
    step(); exp_out(1, "t4c3", 0, 0, 0, 0, 0);
    req[2] = 2'b01; rsrc[2] = 4'b0001; rdst[2] = 8'h08;
    step(); exp_out(2, "t5c1", 4'b0010, 0, 0, 0, 1);
    step(); exp_out(2, "t5c2", 4'b0010, 0, 0, 0, 1);
    reset = 1'b1;
    step(); exp_out(2, "t5rst", 0, 0, 0, 0, 0);
    chk("t5rst.gid", gid[2], 0);
    reset = 1'b0;
    rsrc[2] = 4'b0011; rdst[2] = 8'h01;
    step(); exp_out(2, "t5c4", 4'b1000, 0, 0, 0, 1);
    step();
    step();
    step(); exp_out(2, "t5c7", 4'b1000, 4'b0001, 0, 0, 1);
    step(); exp_out(2, "t5c8", 0, 0, 2'b01, 0, 1);
    req[2] = 2'b00;
    do_reset();
    tg = -1000; ts = 0; te = 0; tid = 0; tend = 0; trej = 1'b0;
    free_at = 0; mask_id = -1; rr = 1; issued = 0; dones = 0;
    for (int j = 0; j < 4; j++) begin
      ref_r[j] = 8'($urandom);
      env_r[j] = ref_r[j];
    end
    for (int c = 0; c < 20000 && dones < NT; c++) begin
      step();
      off = c - tg;
      e_en = (!trej && off >= 1 && off <= S + 1) ? 4'(1 << ts) : 4'b0;
      e_lat = (!trej && off == S + 1) ? 4'(te) : 4'b0;
      e_ack = off == tend ? 2'(1 << tid) : 2'b0;
      e_busy = off >= 1 && off <= tend;
      exp_out(0, "rnd", e_en, e_lat, e_ack, trej ? e_ack : 2'b0, e_busy);
      chk("rnd.gid", gid[0], e_busy ? tid : 0);
      chk("inv.one", $countones(en[0]) <= 1, 1);
      chk("inv.self", en[0] & lat[0], 0);
      chk("inv.lat", lat[0] != 0 && en[0] == 0, 0);
      bus = '0;
      for (int k = 0; k < 4; k++) if (en[0][k]) bus |= env_r[k];
      for (int j = 0; j < 4; j++) if (lat[0][j]) env_r[j] = bus;
      if (off == tend) begin
        dones++;
        if (!trej) for (int j = 0; j < 4; j++) chk($sformatf("sb.r%0d", j), env_r[j], ref_r[j]);
      end
      for (int i = 0; i < 2; i++)
        if (ack[0][i]) req[0][i] = 1'b0;
        else if (!req[0][i] && issued < NT && $urandom_range(0, 2) == 0) begin
          rsrc[0][2*i +: 2] = 2'($urandom);
          rdst[0][4*i +: 4] = 4'($urandom);
          req[0][i] = 1'b1;
          issued++;
        end
      if (c >= free_at) begin
        m = (c == free_at && mask_id >= 0) ? 2'(1 << mask_id) : 2'b0;
        elig = req[0] & ~m;
        w = -1;
        for (int k = 1; k <= 2; k++) if (w < 0 && elig[(rr + k) % 2]) w = (rr + k) % 2;
        if (w >= 0) begin
          tg = c; tid = w; rr = w; mask_id = w;
          ts = int'(rsrc[0][2*w +: 2]);
          te = int'(rdst[0][4*w +: 4]) & ~(1 << ts);
          trej = te == 0;
          tend = trej ? 1 : S + 2;
          free_at = c + tend + 1;
          if (!trej) for (int j = 0; j < 4; j++) if (te[j]) ref_r[j] = ref_r[ts];
        end
      end
    end
    chk("rnd.done", dones, NT);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
